instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Y86-style fetch stage upstream of instruction_counter. Reads a byte-wide
//   synchronous instruction memory one byte per cycle from the current PC and
//   assembles one variable-length instruction (icode/ifun, rA/rB, valC).
//   Presents it with a valid/ready handshake. The icode output drives
//   instruction_counter.icode_input.
// PARAMETERS
//   ADDR_W       16   instruction memory / PC address width
//   CONST_BYTES  8    bytes in valC; valc width = 8*CONST_BYTES
//   RESET_PC     0    PC value loaded on reset
// PORTS
//   clock          in   1        single clock, rising edge
//   reset          in   1        asynchronous, active-low reset
//   mem_rd_en      out  1        memory read request this cycle
//   mem_addr       out  ADDR_W   read address; data is returned on the next cycle
//   mem_rd_data    in   8        byte for the request issued in the previous cycle
//   pc_load        in   1        redirect: abort the current fetch, restart at pc_load_value
//   pc_load_value  in   ADDR_W   redirect target
//   out_valid      out  1        assembled instruction is valid
//   out_ready      in   1        consumer accepts when out_valid and out_ready are both high
//   icode, ifun    out  4 each   byte0[7:4], byte0[3:0]
//   ra, rb         out  4 each   regid byte [7:4], [3:0]; 4'hF if no regid byte
//   valc           out  8*CB     little-endian constant; 0 if none
//   valp           out  ADDR_W   PC + instruction length (wraps mod 2^ADDR_W)
//   halted         out  1        halt instruction accepted; fetching stopped
//   instr_error    out  1        invalid icode seen; fetching stopped
// BEHAVIOUR
//   - Reset (reset=0): state=FETCH0, pc=RESET_PC, mem_rd_en=0. All outputs are 0,
//     except ra=rb=4'hF. Takes effect immediately and aborts any fetch.
//   - Length L by icode:
//       0 halt, 1 nop, 9 ret                  -> L=1
//       2 cmov, 6 OPq, A push, B pop          -> L=2
//       7 jXX, 8 call                         -> L=1+CB (no regid byte)
//       3 irmovq, 4 rmmovq, 5 mrmovq          -> L=2+CB
//       C..F                                  -> invalid
//   - States:
//     FETCH0: mem_rd_en=1, mem_addr=pc; go to DEC0.
//     DEC0: capture byte0.
//       Invalid icode -> ERR.
//       L=1 -> OUT.
//       Otherwise, in the same cycle, request pc+1 (mem_addr is combinational
//       from mem_rd_data) and go to BYTES.
//     BYTES: capture byte k (k=1..L-1) into regid or valC byte (k-regbytes-1).
//       If k=L-1 -> OUT. Otherwise request pc+k+1.
//     OUT: out_valid=1, all fields stable, mem_rd_en=0.
//       On out_ready: pc<=valp; icode 0 -> HALT, otherwise -> FETCH0.
//     HALT: halted=1, no reads. ERR: instr_error=1, no reads.
//       Both are left only by reset or pc_load.
//   - Latency: out_valid rises exactly L+1 cycles after entering FETCH0.
//     Back-to-back throughput is one instruction per L+2 cycles with out_ready held high.
//   - pc_load has priority in every state:
//     pc<=pc_load_value; next state FETCH0; out_valid, halted, instr_error clear next cycle.
//     Partially captured bytes are discarded; data returning for an aborted request is ignored.
//     If pc_load coincides with an OUT handshake, the transfer counts, but pc takes pc_load_value.
//   - Address and valp arithmetic wrap modulo 2^ADDR_W.
//     An instruction spanning the top address continues at 0.
//   - Fields are cleared (valc=0, ra=rb=F) at DEC0, so no stale bytes leak between instructions.
// TESTING
//   1. mem[0]=10 (nop), out_ready=1 -> out_valid in cycle 2 after release;
//      icode=1, valp=1, ra=rb=F; next mem_addr=1.
//   2. mem[0..9]=30 F3 EF CD AB 89 67 45 23 01 -> cycle 11: icode=3, ra=F, rb=3,
//      valc=64'h0123456789ABCDEF, valp=10.
//   3. jXX 70 + 8 bytes, out_ready=0 for 5 cycles -> out_valid held, fields stable,
//      mem_rd_en=0; accepted on ready, valp=9.
//   4. mem[0]=00 (halt) -> accept, then halted=1 and mem_rd_en stays 0 for 20 cycles;
//      pc_load=1, pc_load_value=0x20 -> fetch resumes at 0x20.
//   5. mem[0]=C0 -> instr_error=1 in cycle 2, out_valid=0, no further reads.
//   6. Irmovq at 0:
//      - pc_load (0x40) in cycle 4 -> next mem_addr=0x40, old bytes absent from output.
//      - Separately, reset low in cycle 5 -> outputs at reset values immediately.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - Y86-style variable-length instruction fetch stage
module instruction_fetch #(
    parameter int                ADDR_W      = 16,
    parameter int                CONST_BYTES = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [7:0]               mem_rd_data,
    input  logic                     pc_load,
    input  logic [ADDR_W-1:0]        pc_load_value,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               icode,
    output logic [3:0]               ifun,
    output logic [3:0]               ra,
    output logic [3:0]               rb,
    output logic [8*CONST_BYTES-1:0] valc,
    output logic [ADDR_W-1:0]        valp,
    output logic                     halted,
    output logic                     instr_error
);

    localparam int VALC_W = 8 * CONST_BYTES;
    localparam int K_W    = $clog2(CONST_BYTES + 3);

    typedef enum logic [2:0] {
        S_FETCH0,
        S_DEC0,
        S_BYTES,
        S_OUT,
        S_HALT,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [3:0]          r_icode;
    logic [3:0]          r_ifun;
    logic [3:0]          r_ra;
    logic [3:0]          r_rb;
    logic [VALC_W-1:0]   r_valc;
    logic [ADDR_W-1:0]   r_valp;
    logic [K_W-1:0]      r_len;
    logic [K_W-1:0]      r_k;
    logic                r_has_reg;

    logic [K_W-1:0]      w_dec_len;
    logic                w_dec_reg;
    logic                w_dec_bad;
    logic [K_W-1:0]      w_cidx;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_addr;

    // Length and regid presence of the instruction whose first byte is on mem_rd_data
    always_comb begin
        w_dec_len = K_W'(1);
        w_dec_reg = 1'b0;
        w_dec_bad = 1'b0;
        case (mem_rd_data[7:4])
            4'h0, 4'h1, 4'h9: w_dec_len = K_W'(1);
            4'h2, 4'h6, 4'hA, 4'hB: begin
                w_dec_len = K_W'(2);
                w_dec_reg = 1'b1;
            end
            4'h7, 4'h8: w_dec_len = K_W'(1 + CONST_BYTES);
            4'h3, 4'h4, 4'h5: begin
                w_dec_len = K_W'(2 + CONST_BYTES);
                w_dec_reg = 1'b1;
            end
            default: w_dec_bad = 1'b1;
        endcase
    end

    // Byte position inside valC for the byte currently arriving in BYTES
    assign w_cidx = r_k - K_W'(r_has_reg) - K_W'(1);

    // Next state and memory request; a redirect overrides every state
    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        w_addr  = r_pc;
        case (r_state)
            S_FETCH0: begin
                w_rd_en = 1'b1;
                w_addr  = r_pc;
                w_next  = S_DEC0;
            end
            S_DEC0: begin
                if (w_dec_bad) begin
                    w_next = S_ERR;
                end else if (w_dec_len == K_W'(1)) begin
                    w_next = S_OUT;
                end else begin
                    w_rd_en = 1'b1;
                    w_addr  = r_pc + ADDR_W'(1);
                    w_next  = S_BYTES;
                end
            end
            S_BYTES: begin
                if (r_k == r_len - K_W'(1)) begin
                    w_next = S_OUT;
                end else begin
                    w_rd_en = 1'b1;
                    w_addr  = r_pc + ADDR_W'(r_k) + ADDR_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_next = (r_icode == 4'h0) ? S_HALT : S_FETCH0;
                end
            end
            S_HALT:  w_next = S_HALT;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_FETCH0;
        endcase
        if (pc_load) begin
            w_next = S_FETCH0;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH0;
        end else begin
            r_state <= w_next;
        end
    end

    // PC, byte counter and instruction field capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_icode   <= 4'h0;
            r_ifun    <= 4'h0;
            r_ra      <= 4'hF;
            r_rb      <= 4'hF;
            r_valc    <= '0;
            r_valp    <= '0;
            r_len     <= '0;
            r_k       <= '0;
            r_has_reg <= 1'b0;
        end else if (pc_load) begin
            r_pc <= pc_load_value;
        end else begin
            case (r_state)
                S_DEC0: begin
                    r_icode   <= mem_rd_data[7:4];
                    r_ifun    <= mem_rd_data[3:0];
                    r_ra      <= 4'hF;
                    r_rb      <= 4'hF;
                    r_valc    <= '0;
                    r_len     <= w_dec_len;
                    r_has_reg <= w_dec_reg;
                    r_k       <= K_W'(1);
                    r_valp    <= r_pc + ADDR_W'(w_dec_len);
                end
                S_BYTES: begin
                    if (r_has_reg && r_k == K_W'(1)) begin
                        r_ra <= mem_rd_data[7:4];
                        r_rb <= mem_rd_data[3:0];
                    end else begin
                        r_valc[8*w_cidx +: 8] <= mem_rd_data;
                    end
                    r_k <= r_k + K_W'(1);
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_pc <= r_valp;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory port is forced quiet while reset is asserted
    assign mem_rd_en   = w_rd_en & reset;
    assign mem_addr    = reset ? w_addr : '0;
    assign out_valid   = (r_state == S_OUT);
    assign halted      = (r_state == S_HALT);
    assign instr_error = (r_state == S_ERR);
    assign icode       = r_icode;
    assign ifun        = r_ifun;
    assign ra          = r_ra;
    assign rb          = r_rb;
    assign valc        = r_valc;
    assign valp        = r_valp;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [15:0] valp;
    logic        halted;
    logic        instr_error;

    logic [7:0]  mem [0:65535];
    logic [95:0] exp_q [$];
    int          nvec = 0;
    int          nbad = 0;
    bit          rnd_ready = 0;

    instruction_fetch #(.ADDR_W(16), .CONST_BYTES(8), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pc_load(pc_load), .pc_load_value(pc_load_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .ra(ra), .rb(rb), .valc(valc), .valp(valp),
        .halted(halted), .instr_error(instr_error)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // Synchronous byte-wide instruction memory
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Monitor: every accepted instruction is compared against the scoreboard head
    always @(negedge clock) begin
        logic [95:0] got;
        logic [95:0] e;
        if (reset && out_valid && out_ready) begin
            got = {icode, ifun, ra, rb, valc, valp};
            nvec++;
            if (exp_q.size() == 0) begin
                nbad++;
                $display("FAIL unexpected_instr got=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    nbad++;
                    $display("FAIL instr got=%h required=%h", got, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h required=%0h", nm, got, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules
    function automatic logic [95:0] ref_decode(input logic [15:0] pc, output bit ok);
        logic [7:0]  b0;
        logic [3:0]  ic;
        logic [3:0]  r_a;
        logic [3:0]  r_b;
        logic [63:0] vc;
        logic [15:0] a;
        bit          hr;
        bit          hc;
        int          len;
        b0  = mem[pc];
        ic  = b0[7:4];
        r_a = 4'hF;
        r_b = 4'hF;
        vc  = '0;
        hr  = 0;
        hc  = 0;
        ok  = 1;
        case (ic)
            4'h0, 4'h1, 4'h9: ;
            4'h2, 4'h6, 4'hA, 4'hB: hr = 1;
            4'h7, 4'h8: hc = 1;
            4'h3, 4'h4, 4'h5: begin hr = 1; hc = 1; end
            default: ok = 0;
        endcase
        len = 1 + int'(hr) + (hc ? 8 : 0);
        a = pc + 16'd1;
        if (hr) begin
            r_a = mem[a][7:4];
            r_b = mem[a][3:0];
            a   = a + 16'd1;
        end
        if (hc) begin
            for (int i = 0; i < 8; i++) begin
                vc[8*i +: 8] = mem[a];
                a = a + 16'd1;
            end
        end
        return {ic, b0[3:0], r_a, r_b, vc, pc + 16'(len)};
    endfunction

    // Push the expected instruction stream starting at pc until halt or invalid
    task automatic walk(input logic [15:0] start);
        logic [15:0] pc;
        logic [95:0] e;
        bit          ok;
        pc = start;
        for (int s = 0; s < 64; s++) begin
            e = ref_decode(pc, ok);
            if (!ok) break;
            exp_q.push_back(e);
            if (e[95:92] == 4'h0) break;
            pc = e[15:0];
        end
    endtask

    task automatic gen_prog(input logic [15:0] start, input int n);
        logic [15:0] a;
        logic [3:0]  ic;
        int          len;
        a = start;
        for (int i = 0; i < n; i++) begin
            ic = 4'($urandom_range(1, 11));
            mem[a] = {ic, 4'($urandom)};
            case (ic)
                4'h1, 4'h9: len = 1;
                4'h2, 4'h6, 4'hA, 4'hB: len = 2;
                4'h7, 4'h8: len = 9;
                default: len = 10;
            endcase
            for (int j = 1; j < len; j++) mem[a + 16'(j)] = 8'($urandom);
            a = a + 16'(len);
        end
        if ($urandom_range(0, 3) == 0) mem[a] = {4'($urandom_range(12, 15)), 4'($urandom)};
        else mem[a] = 8'h00;
    endtask

    task automatic check_rst(input string nm);
        check(nm, {mem_rd_en, out_valid, halted, instr_error, icode, ifun, ra, rb, valc, valp, mem_addr},
              {4'b0000, 8'h00, 8'hFF, 64'h0, 16'h0, 16'h0});
    endtask

    task automatic do_reset();
        reset = 0;
        pc_load = 0;
        pc_load_value = '0;
        out_ready = 1;
        rnd_ready = 0;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        check_rst("reset_vals");
    endtask

    task automatic start_at(input logic [15:0] target);
        reset = 1;
        pc_load = 1;
        pc_load_value = target;
        @(posedge clock);
        #1;
        pc_load = 0;
    endtask

    task automatic run_to_end(input string nm);
        int n;
        n = 0;
        while (!(halted || instr_error) && n < 2000) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clock);
            #1;
            n++;
        end
        out_ready = 1;
        check({nm, "_finished"}, 128'(n < 2000), 128'(1));
        check({nm, "_drained"}, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic wait_valid(input string nm, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({nm, "_latency"}, 128'(n), 128'(exp_lat));
    endtask

    task automatic load_irmovq();
        logic [7:0] bytes [10];
        bytes = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        for (int i = 0; i < 10; i++) mem[i] = bytes[i];
    endtask

    initial begin
        bit          ok;
        int          n;
        logic [95:0] e;
        logic [15:0] st;

        // nop at 0
        do_reset();
        mem[0] = 8'h10; mem[1] = 8'h00;
        walk(16'h0);
        reset = 1;
        wait_valid("nop", 2);
        check("nop_fields", {icode, ra, rb, valp}, {4'h1, 4'hF, 4'hF, 16'h1});
        @(posedge clock); #1;
        check("nop_next_addr", {mem_rd_en, mem_addr}, {1'b1, 16'h1});
        run_to_end("nop");

        // irmovq with full constant
        do_reset();
        load_irmovq();
        mem[10] = 8'h00;
        walk(16'h0);
        reset = 1;
        wait_valid("irmovq", 11);
        check("irmovq_fields", {icode, ra, rb, valc, valp},
              {4'h3, 4'hF, 4'h3, 64'h0123456789ABCDEF, 16'd10});
        run_to_end("irmovq");

        // jXX held by out_ready low
        do_reset();
        mem[0] = 8'h70;
        for (int i = 1; i < 9; i++) mem[i] = 8'($urandom);
        mem[9] = 8'h00;
        e = ref_decode(16'h0, ok);
        walk(16'h0);
        out_ready = 0;
        reset = 1;
        wait_valid("jxx", 10);
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (!out_valid || mem_rd_en || {icode, ifun, ra, rb, valc, valp} !== e) ok = 0;
        end
        check("jxx_stall_hold", 128'(ok), 128'(1));
        check("jxx_valp", 128'(valp), 128'(9));
        run_to_end("jxx");

        // halt, then redirect out of HALT
        do_reset();
        mem[0] = 8'h00; mem[16'h20] = 8'h10; mem[16'h21] = 8'h00;
        walk(16'h0);
        reset = 1;
        run_to_end("halt");
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (!halted || mem_rd_en) ok = 0;
        end
        check("halt_quiet", 128'(ok), 128'(1));
        walk(16'h20);
        pc_load = 1; pc_load_value = 16'h20;
        @(posedge clock); #1;
        pc_load = 0;
        check("halt_resume", {halted, mem_rd_en, mem_addr}, {1'b0, 1'b1, 16'h20});
        run_to_end("resume");

        // invalid icode
        do_reset();
        mem[0] = 8'hC0;
        walk(16'h0);
        reset = 1;
        n = 0;
        while (!instr_error && n < 50) begin @(posedge clock); #1; n++; end
        check("err_latency", 128'(n), 128'(2));
        check("err_no_valid", 128'(out_valid), 128'(0));
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (mem_rd_en) ok = 0;
        end
        check("err_quiet", 128'(ok), 128'(1));
        check("err_drained", 128'(exp_q.size()), 128'(0));

        // redirect in the middle of an irmovq
        do_reset();
        load_irmovq();
        mem[16'h40] = 8'h10; mem[16'h41] = 8'h00;
        walk(16'h40);
        reset = 1;
        repeat (4) begin @(posedge clock); #1; end
        pc_load = 1; pc_load_value = 16'h40;
        @(posedge clock); #1;
        pc_load = 0;
        check("redirect_addr", {mem_rd_en, mem_addr}, {1'b1, 16'h40});
        run_to_end("redirect");

        // reset asserted mid-fetch
        do_reset();
        load_irmovq();
        reset = 1;
        repeat (5) begin @(posedge clock); #1; end
        reset = 0;
        #1;
        check_rst("midfetch_reset");

        // instruction spanning the top of the address space
        do_reset();
        mem[16'hFFFE] = 8'h30; mem[16'hFFFF] = 8'h45;
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
        mem[8] = 8'h00;
        walk(16'hFFFE);
        start_at(16'hFFFE);
        run_to_end("wrap");

        // randomized programs with random back-pressure
        for (int it = 0; it < 30; it++) begin
            do_reset();
            st = 16'($urandom);
            gen_prog(st, $urandom_range(1, 6));
            walk(st);
            rnd_ready = 1;
            start_at(st);
            run_to_end("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
